// File: rtl/qec_pkg.sv
// Shared definitions for the QEC repetition-code syndrome generator.
// Optional LFSR error injection is enabled with QEC_LFSR_INJECT_EN.
package qec_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENCODE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam logic [2:0] SYND_NONE = 3'b000;
  localparam logic [2:0] SYND_Q0   = 3'b011;
  localparam logic [2:0] SYND_Q1   = 3'b101;
  localparam logic [2:0] SYND_Q2   = 3'b110;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [2:0] syndrome_of(input logic [2:0] cw);
    syndrome_of = {cw[1] ^ cw[2], cw[0] ^ cw[2], cw[0] ^ cw[1]};
  endfunction

  function automatic logic [2:0] onehot_of(input logic [1:0] sel);
    case (sel)
      2'b00:   onehot_of = 3'b000;
      2'b01:   onehot_of = 3'b001;
      2'b10:   onehot_of = 3'b010;
      2'b11:   onehot_of = 3'b100;
      default: onehot_of = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/qec_lfsr8.sv
// 8-bit Fibonacci LFSR that advances every cycle; synchronous active-low reset to seed.
module qec_lfsr8
  import qec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feeding back the parity of the tapped bits
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // LFSR state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/qec_syndrome_gen.sv
// Encodes a logical bit into a 3-qubit repetition codeword and streams ROUNDS syndromes.
// QEC_LFSR_INJECT_EN adds inj_rand and an LFSR-chosen single-qubit error.
module qec_syndrome_gen
  import qec_pkg::*;
#(
  parameter int         ROUNDS    = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic [2:0] err_mask,
  input  logic [2:0] meas_err,
  output logic       synd_valid,
  input  logic       synd_ready,
  output logic [2:0] syndrome,
  output logic       synd_last,
  output logic [2:0] codeword,
`ifdef QEC_LFSR_INJECT_EN
  input  logic       inj_rand,
`endif
  output logic       busy
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  logic [1:0]    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          bit_q, bit_d;
  logic [2:0]    mask_q, mask_d;
  logic [2:0]    meas_q, meas_d;
  logic [2:0]    codeword_q, codeword_d;
  logic [RW-1:0] round_q, round_d;
  logic [2:0]    accept_mask_s;
  logic          last_s;

`ifdef QEC_LFSR_INJECT_EN
  logic [7:0] lfsr_s;

  qec_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_s)
  );

  // Injected mask overrides err_mask when requested at acceptance
  always_comb begin
    if (inj_rand) begin
      accept_mask_s = onehot_of(lfsr_s[1:0]);
    end else begin
      accept_mask_s = err_mask;
    end
  end
`else
  logic [7:0] unused_seed_s;
  assign unused_seed_s = LFSR_SEED;

  // Without injection the caller's mask is always taken
  always_comb begin
    accept_mask_s = err_mask;
  end
`endif

  assign last_s = (round_q == LAST_ROUND);

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    mask_d     = mask_q;
    meas_d     = meas_q;
    codeword_d = codeword_q;
    round_d    = round_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          bit_d   = in_bit;
          mask_d  = accept_mask_s;
          meas_d  = meas_err;
          state_d = ST_ENCODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        codeword_d = {3{bit_q}} ^ mask_q;
        round_d    = {RW{1'b0}};
        state_d    = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (synd_ready) begin
          if (last_s) begin
            state_d = ST_IDLE;
          end else begin
            round_d = round_q + RW'(1);
          end
        end else begin
          state_d = ST_MEASURE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; in_ready stays low through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      bit_q      <= 1'b0;
      mask_q     <= 3'b000;
      meas_q     <= 3'b000;
      codeword_q <= 3'b000;
      round_q    <= {RW{1'b0}};
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      bit_q      <= bit_d;
      mask_q     <= mask_d;
      meas_q     <= meas_d;
      codeword_q <= codeword_d;
      round_q    <= round_d;
    end
  end

  // Outputs decoded from registers only; measurement error hits round 0 alone
  always_comb begin
    if (state_q == ST_MEASURE) begin
      synd_valid = 1'b1;
      synd_last  = last_s;
      if (round_q == {RW{1'b0}}) begin
        syndrome = syndrome_of(codeword_q) ^ meas_q;
      end else begin
        syndrome = syndrome_of(codeword_q);
      end
    end else begin
      synd_valid = 1'b0;
      synd_last  = 1'b0;
      syndrome   = SYND_NONE;
    end
  end

  assign in_ready = in_ready_q;
  assign codeword = codeword_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qec_syndrome_gen.sv
// Directed-vector bench for qec_syndrome_gen (ROUNDS=3); QEC_LFSR_INJECT_EN adds the injection test.
module tb_qec_syndrome_gen;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [2:0] err_mask;
  logic [2:0] meas_err;
  logic       synd_valid;
  logic       synd_ready;
  logic [2:0] syndrome;
  logic       synd_last;
  logic [2:0] codeword;
  logic       busy;
`ifdef QEC_LFSR_INJECT_EN
  logic       inj_rand;
`endif

  int n_vec = 0;
  int n_bad = 0;

  qec_syndrome_gen #(.ROUNDS(3), .LFSR_SEED(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .err_mask   (err_mask),
    .meas_err   (meas_err),
    .synd_valid (synd_valid),
    .synd_ready (synd_ready),
    .syndrome   (syndrome),
    .synd_last  (synd_last),
    .codeword   (codeword),
`ifdef QEC_LFSR_INJECT_EN
    .inj_rand   (inj_rand),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; err_mask = 3'b000;
    meas_err = 3'b000; synd_ready = 1'b1;
`ifdef QEC_LFSR_INJECT_EN
    inj_rand = 1'b0;
`endif
    tick(); tick();
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++; if (synd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_synd_valid got %b want 0", synd_valid); end
    n_vec++; if (synd_last !== 1'b0) begin n_bad++; $display("FAIL reset_synd_last got %b want 0", synd_last); end
    n_vec++; if (syndrome !== 3'b000) begin n_bad++; $display("FAIL reset_syndrome got %b want 000", syndrome); end
    n_vec++; if (codeword !== 3'b000) begin n_bad++; $display("FAIL reset_codeword got %b want 000", codeword); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  // One full transaction with synd_ready held high; inputs are scrambled after acceptance
  task automatic test_vector(input string nm, input logic b, input logic [2:0] m,
                             input logic [2:0] me, input logic [2:0] exp_cw,
                             input logic [2:0] exp_s0, input logic [2:0] exp_s);
    synd_ready = 1'b1;
    in_valid = 1'b1; in_bit = b; err_mask = m; meas_err = me;
    tick();
    in_valid = 1'b0; in_bit = ~b; err_mask = ~m; meas_err = ~me;
    n_vec++; if (synd_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
      begin n_bad++; $display("FAIL %s_encode valid/busy/ready got %b%b%b want 010", nm, synd_valid, busy, in_ready); end
    tick();
    n_vec++; if (codeword !== exp_cw) begin n_bad++; $display("FAIL %s_codeword got %b want %b", nm, codeword, exp_cw); end
    for (int r = 0; r < 3; r++) begin
      logic [2:0] es;
      es = (r == 0) ? exp_s0 : exp_s;
      n_vec++; if (synd_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid_r%0d got %b want 1", nm, r, synd_valid); end
      n_vec++; if (syndrome !== es) begin n_bad++; $display("FAIL %s_syndrome_r%0d got %b want %b", nm, r, syndrome, es); end
      n_vec++; if (synd_last !== (r == 2)) begin n_bad++; $display("FAIL %s_last_r%0d got %b want %b", nm, r, synd_last, (r == 2)); end
      tick();
    end
    n_vec++; if (in_ready !== 1'b1 || synd_valid !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL %s_done ready/valid/busy got %b%b%b want 100", nm, in_ready, synd_valid, busy); end
  endtask

  task automatic test_clean();
    test_vector("clean", 1'b1, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000);
  endtask

  task automatic test_single_flips();
    test_vector("flip_q1", 1'b0, 3'b010, 3'b000, 3'b010, 3'b101, 3'b101);
    test_vector("flip_q0", 1'b0, 3'b001, 3'b000, 3'b001, 3'b011, 3'b011);
    test_vector("flip_q2", 1'b0, 3'b100, 3'b000, 3'b100, 3'b110, 3'b110);
    test_vector("double_q01", 1'b1, 3'b011, 3'b000, 3'b100, 3'b110, 3'b110);
  endtask

  task automatic test_meas_err();
    test_vector("meas_err", 1'b0, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000);
  endtask

  task automatic test_backpressure();
    synd_ready = 1'b1;
    in_valid = 1'b1; in_bit = 1'b0; err_mask = 3'b001; meas_err = 3'b010;
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++; if (syndrome !== 3'b001) begin n_bad++; $display("FAIL bp_r0_syndrome got %b want 001", syndrome); end
    tick();
    synd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (synd_valid !== 1'b1 || syndrome !== 3'b011 || synd_last !== 1'b0)
        begin n_bad++; $display("FAIL bp_stall%0d valid/synd/last got %b/%b/%b want 1/011/0", i, synd_valid, syndrome, synd_last); end
      tick();
    end
    synd_ready = 1'b1;
    n_vec++; if (syndrome !== 3'b011 || synd_last !== 1'b0) begin n_bad++; $display("FAIL bp_r1_release synd/last got %b/%b want 011/0", syndrome, synd_last); end
    tick();
    n_vec++; if (synd_last !== 1'b1 || syndrome !== 3'b011) begin n_bad++; $display("FAIL bp_r2 last/synd got %b/%b want 1/011", synd_last, syndrome); end
    tick();
    n_vec++; if (in_ready !== 1'b1 || synd_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done ready/valid got %b/%b want 1/0", in_ready, synd_valid); end
  endtask

  task automatic test_reset_mid_measure();
    synd_ready = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1; err_mask = 3'b010; meas_err = 3'b000;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_vec++; if (synd_valid !== 1'b1 || codeword !== 3'b101) begin n_bad++; $display("FAIL rmid_pre valid/cw got %b/%b want 1/101", synd_valid, codeword); end
    rst_n = 1'b0;
    tick();
    n_vec++; if (synd_valid !== 1'b0 || codeword !== 3'b000 || busy !== 1'b0 || in_ready !== 1'b0)
      begin n_bad++; $display("FAIL rmid_reset valid/cw/busy/ready got %b/%b/%b/%b want 0/000/0/0", synd_valid, codeword, busy, in_ready); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1 || synd_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_release ready/valid got %b/%b want 1/0", in_ready, synd_valid); end
  endtask

`ifdef QEC_LFSR_INJECT_EN
  // Seed A5 advances once before acceptance: A5 -> 4A, lfsr[1:0]=10 -> mask 010
  task automatic test_inject();
    rst_n = 1'b0; in_valid = 1'b0; inj_rand = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    inj_rand = 1'b1; in_valid = 1'b1; in_bit = 1'b0; err_mask = 3'b100; meas_err = 3'b000;
    synd_ready = 1'b1;
    tick();
    in_valid = 1'b0; inj_rand = 1'b0;
    tick();
    n_vec++; if (codeword !== 3'b010) begin n_bad++; $display("FAIL inject_codeword got %b want 010", codeword); end
    n_vec++; if (syndrome !== 3'b101) begin n_bad++; $display("FAIL inject_syndrome got %b want 101", syndrome); end
    tick(); tick(); tick();
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL inject_done in_ready got %b want 1", in_ready); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef QEC_LFSR_INJECT_EN
    test_inject();
`endif
    test_clean();
    test_single_flips();
    test_meas_err();
    test_backpressure();
    test_reset_mid_measure();
    test_clean();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qec_syndrome_gen.md
# qec_syndrome_gen

Stimulus-side partner of the 3-qubit repetition-code syndrome decoder. Accepts a logical bit over a valid/ready handshake, encodes it to a 3-bit codeword, applies a data-error pattern, then streams ROUNDS syndrome measurements over a second valid/ready handshake. Each measurement uses the decoder's syndrome convention, so `syndrome` can drive the decoder's `ui_in[2:0]` directly. Sits between the test/stimulus logic and the decoder in the QEC demo datapath.

## Interface
Parameters:
- ROUNDS, 3: syndrome measurement rounds per accepted bit, legal range 1..15.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  logical bit offered.
- in_ready  out  1  block can accept (high only in IDLE).
- in_bit  in  1  logical bit to encode.
- err_mask  in  3  data-qubit flip pattern, bit k = qubit k.
- meas_err  in  3  measurement-error XOR, applied to round 0 only.
- synd_valid  out  1  syndrome presented.
- synd_ready  in  1  consumer accepts syndrome.
- syndrome  out  3  {q1^q2, q0^q2, q0^q1} ^ round-0 meas_err.
- synd_last  out  1  high with the final round's syndrome.
- codeword  out  3  current (errored) codeword register.
- busy  out  1  high in every state except IDLE.
- inj_rand  in  1  present only with QEC_LFSR_INJECT_EN.

## Operation
- States: IDLE, ENCODE, MEASURE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_bit, err_mask and meas_err; go to ENCODE.
- ENCODE (one cycle):
  - codeword <= {3{bit}} ^ mask.
  - round <= 0.
  - Go to MEASURE.
- MEASURE:
  - synd_valid=1.
  - syndrome = parity(codeword), XORed with the latched meas_err when round==0.
  - synd_last = (round==ROUNDS-1).
  - On synd_valid&&synd_ready: if last, go to IDLE; else round++.
- Syndrome mapping for the clean case:
  - No error -> 000.
  - q0 flip -> 011; q1 flip -> 101; q2 flip -> 110.
  - Two data flips alias to the third qubit's single-flip pattern.
  - Clean syndromes always have even parity. 001/010/100/111 arise only from meas_err.
- round counter width: $clog2(ROUNDS+1). No wrap occurs because exit is on last.
- Latched inputs are stable from acceptance until return to IDLE. Inputs changing mid-operation have no effect.
- Reset values: in_ready=0 during reset and 1 on the first post-reset cycle; synd_valid=0; synd_last=0; syndrome=000; codeword=000; busy=0; state=IDLE; round=0; LFSR=LFSR_SEED.
- Reset mid-operation discards the pending bit with no partial syndrome handshake; the next cycle is IDLE.

## Timing
- Acceptance at edge N.
- ENCODE occupies cycle N+1.
- synd_valid is first high in cycle N+2 (2-cycle latency).
- Each round lasts ≥1 cycle and stalls indefinitely while synd_ready=0. syndrome and synd_last hold stable under stall.
- Minimum 2+ROUNDS cycles per bit. in_ready returns high the cycle after the last handshake; no back-to-back overlap.
- All outputs are registered or decoded from state and registers only. There are no combinational paths from inputs to outputs, and in_ready does not depend on in_valid.

## Configuration
- QEC_LFSR_INJECT_EN defined:
  - Adds the `inj_rand` port and an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  - The LFSR advances every cycle.
  - If inj_rand=1 at acceptance, the latched mask = one-hot from lfsr[1:0] (00->000, 01->001, 10->010, 11->100) and err_mask is ignored.
- Undefined: no LFSR and no inj_rand port; err_mask is always used.

## Structure
- qec_pkg holds:
  - state enum (IDLE, ENCODE, MEASURE);
  - function syndrome_of(logic [2:0] cw);
  - constants for the four clean syndromes;
  - LFSR tap constant.
- Sub-module qec_lfsr8 (clk, rst_n, seed, q[7:0]) is instantiated only under the macro.

## Test plan
- Clean path: in_bit=1, err_mask=000, meas_err=000, ROUNDS=3, synd_ready=1 -> codeword=111; syndrome 000 for 3 cycles starting N+2; synd_last on the 3rd; in_ready high at N+5.
- Single flips: in_bit=0, err_mask=010 -> codeword=010, every round syndrome=101; err_mask=001 -> 011; err_mask=100 -> 110.
- Measurement error: err_mask=000, meas_err=111 -> round 0 syndrome=111, rounds 1–2 syndrome=000.
- Backpressure: synd_ready=0 for 5 cycles during round 1 -> syndrome/synd_last stable, round not advanced; completion occurs 5 cycles later.
- Reset mid-MEASURE: assert rst_n=0 at round 1 -> next cycle synd_valid=0, codeword=000, in_ready=1 after release.
- (Macro) inj_rand=1 with LFSR_SEED=8'hA5, accepted on the first post-reset cycle -> mask equals the one-hot decode of the lfsr[1:0] value at acceptance; syndrome matches that mask.
